// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the MEM stage,
// sequencing req/ack accesses and stalling each stage until its access completes.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_done,
    output logic          mem_stall,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          err,
    output logic [2:0]    dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_WAIT = 3'd1,
        I_WAIT = 3'd2,
        D_DONE = 3'd3,
        I_DONE = 3'd4
    } state_t;

    // The counter only has to reach TIMEOUT-1; with TIMEOUT=0 it wraps harmlessly.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic          err_q, err_d;
    logic          lg_mem_q, lg_mem_d;

    logic mem_req_w;
    logic timeout_hit;

    assign mem_req_w   = mem_rd | mem_wr;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            err_q       <= 1'b0;
            lg_mem_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            err_q       <= err_d;
            lg_mem_q    <= lg_mem_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        err_d       = err_q;
        lg_mem_d    = lg_mem_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // MEM wins when alone, or when both ask and IF had the last grant.
                if (mem_req_w && (!if_req || !lg_mem_q)) begin
                    m_req_d   = 1'b1;
                    m_we_d    = mem_wr;
                    m_addr_d  = mem_addr;
                    m_wdata_d = mem_wdata;
                    lg_mem_d  = 1'b1;
                    state_d   = D_WAIT;
                end else if (if_req) begin
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr;
                    m_wdata_d = '0;
                    lg_mem_d  = 1'b0;
                    state_d   = I_WAIT;
                end
            end
            D_WAIT, I_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (m_ack) begin
                    m_req_d = 1'b0;
                    if (state_q == D_WAIT) begin
                        if (!m_we_q) mem_rdata_d = m_rdata;
                        state_d = D_DONE;
                    end else begin
                        if_rdata_d = m_rdata;
                        state_d    = I_DONE;
                    end
                end else if (timeout_hit) begin
                    // Give up on the memory but still drain the stage with zero data.
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    if (state_q == D_WAIT) begin
                        if (!m_we_q) mem_rdata_d = '0;
                        state_d = D_DONE;
                    end else begin
                        if_rdata_d = '0;
                        state_d    = I_DONE;
                    end
                end
            end
            D_DONE, I_DONE: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    assign m_req       = m_req_q;
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign mem_rdata   = mem_rdata_q;
    assign err         = err_q;
    assign if_valid    = (state_q == I_DONE);
    assign mem_done    = (state_q == D_DONE);
    assign if_stall    = if_req & ~if_valid;
    assign mem_stall   = mem_req_w & ~mem_done;
    assign dbg_state_o = state_q;

endmodule
